dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have no parameters; all data and address widths are fixed at 32 bits.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have ports: req0, req1  input  1 each  access request from requester 0 / 1.
REQ-005 SHALL have ports: word_we0, word_we1, byte_we0, byte_we1  input  1 each  write type per requester; both 0 means read.
REQ-006 SHALL have ports: addr0, addr1, wdata0, wdata1  input  32 each  access address and write data per requester.
REQ-007 SHALL have port: mem_rdata  input  32  combinational read data from the data memory.
REQ-008 SHALL have ports: mem_addr, mem_wdata  output  32 each  address and write data to the data memory.
REQ-009 SHALL have ports: mem_word_we, mem_byte_we  output  1 each  write enables to the data memory.
REQ-010 SHALL have ports: gnt  output  2  one-hot grant; done  output  2  one-cycle completion pulse per requester.
REQ-011 SHALL have ports: rdata  output  32  registered read result; err  output  1  misaligned-access flag; busy  output  1  high when state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, SERVE, DONE with transitions IDLE->SERVE (any req high), SERVE->DONE (always), DONE->IDLE (always).
REQ-013 SHALL stay in IDLE while req0 = req1 = 0.
REQ-014 SHALL, in IDLE with exactly one req high, grant that requester on the next edge.
REQ-015 SHALL, in IDLE with both req high, grant the requester not recorded in last_grant, then set last_grant to the granted index (round-robin).
REQ-016 SHALL latch the granted requester's addr, wdata, word_we and byte_we on the IDLE->SERVE edge; later input changes SHALL NOT affect the access in progress.
REQ-017 SHALL drive gnt one-hot for the granted index only during SERVE, and 2'b00 otherwise.
REQ-018 SHALL drive mem_addr and mem_wdata from the latched values in every state.
REQ-019 SHALL assert mem_word_we or mem_byte_we only during SERVE, per the latched write type, so the write commits on the SERVE->DONE edge.
REQ-020 SHALL flag a word access (read or write with word_we = 1) whose latched addr[1:0] != 0 as misaligned.
REQ-021 SHALL suppress mem_word_we and mem_byte_we for a misaligned access; byte accesses are never misaligned.
REQ-022 SHALL capture mem_rdata into rdata on the SERVE->DONE edge for reads, and load 0 for writes and misaligned accesses.
REQ-023 SHALL hold rdata until the next DONE.
REQ-024 SHALL pulse done[granted index] for exactly the DONE cycle, and assert err during that cycle only for a misaligned access.
REQ-025 SHALL treat a req still high in IDLE after DONE as a new request; requesters drop req on the done cycle.
REQ-026 SHALL give latency of exactly 2 cycles from the IDLE edge that samples req to done high.
REQ-027 SHALL sustain a throughput of one access per 3 cycles.
REQ-028 SHALL ignore req inputs during SERVE and DONE.
REQ-029 SHALL treat word_we and byte_we both high as a word access.

Reset
REQ-030 SHALL, while reset = 0, force state to IDLE and last_grant to 1 (requester 0 wins the first tie).
REQ-031 SHALL, while reset = 0, drive gnt = 0, done = 0, err = 0, busy = 0, rdata = 0, mem_word_we = 0 and mem_byte_we = 0.
REQ-032 SHALL clear all latched address, data and write fields to 0 while reset = 0.
REQ-033 SHALL, on reset asserted during SERVE, immediately drop the write enables so no memory write occurs, and produce no done pulse.
REQ-034 SHALL begin normal operation on the first rising edge after reset returns to 1.

Verification
REQ-035 Bench SHALL cover: after reset release, req0 and req1 both high with reads -> gnt = 01 in SERVE, done = 01 two cycles after sampling, and the next access grants gnt = 10.
REQ-036 Bench SHALL cover: req1 word write, addr1 = 0x10, wdata1 = 0xDEADBEEF -> mem_word_we = 1 for one cycle; a following req0 read of 0x10 returns rdata = 0xDEADBEEF.
REQ-037 Bench SHALL cover: req0 word write to addr 0x13 -> no write enable asserted; done = 01 with err = 1; rdata = 0.
REQ-038 Bench SHALL cover: req0 byte write to 0x13 -> mem_byte_we = 1; err = 0.
REQ-039 Bench SHALL cover: addr0 changed during SERVE -> mem_addr unchanged from the latched value.
REQ-040 Bench SHALL cover: reset pulled low mid-SERVE of a write -> write enables drop at once; memory unchanged; busy = 0; no done pulse.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for a single-port data memory.
// Each access runs IDLE -> SERVE -> DONE, so one access completes every 3 cycles.
module dmem_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        word_we0,
   input  logic        word_we1,
   input  logic        byte_we0,
   input  logic        byte_we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_word_we,
   output logic        mem_byte_we,
   output logic [1:0]  gnt,
   output logic [1:0]  done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

   state_t      state;
   logic        last_grant;
   logic        idx_q;
   logic        word_q;
   logic        byte_q;
   logic        mis_q;

   logic        pick;
   logic        sel_word;
   logic        sel_byte;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_mis;

   // On a tie the requester that did not win last time is chosen.
   always_comb begin
      pick = 1'b0;
      if (req0 && req1)
         pick = ~last_grant;
      else if (req1)
         pick = 1'b1;
      sel_word  = pick ? word_we1 : word_we0;
      sel_byte  = pick ? byte_we1 : byte_we0;
      sel_addr  = pick ? addr1    : addr0;
      sel_wdata = pick ? wdata1   : wdata0;
      // Only pure byte writes may be unaligned; reads and word writes need addr[1:0] == 0.
      sel_mis   = !(sel_byte && !sel_word) && (sel_addr[1:0] != 2'b00);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         idx_q       <= 1'b0;
         word_q      <= 1'b0;
         byte_q      <= 1'b0;
         mis_q       <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_word_we <= 1'b0;
         mem_byte_we <= 1'b0;
         gnt         <= '0;
         done        <= '0;
         rdata       <= '0;
         err         <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  state       <= SERVE;
                  idx_q       <= pick;
                  last_grant  <= pick;
                  mem_addr    <= sel_addr;
                  mem_wdata   <= sel_wdata;
                  word_q      <= sel_word;
                  byte_q      <= sel_byte;
                  mis_q       <= sel_mis;
                  gnt         <= pick ? 2'b10 : 2'b01;
                  mem_word_we <= sel_word && !sel_mis;
                  mem_byte_we <= sel_byte && !sel_word;
                  busy        <= 1'b1;
               end
            end
            SERVE: begin
               state       <= DONE;
               gnt         <= '0;
               mem_word_we <= 1'b0;
               mem_byte_we <= 1'b0;
               done        <= idx_q ? 2'b10 : 2'b01;
               err         <= mis_q;
               rdata       <= (!word_q && !byte_q && !mis_q) ? mem_rdata : '0;
            end
            DONE: begin
               state <= IDLE;
               done  <= '0;
               err   <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
